kb_scanner: RTL
===============

Name: kb_scanner

Overview:
- Front-end stage for the 2x2 keypad, directly upstream of the calculator core.
- Drives the active-low column lines and samples the active-low row lines.
- Debounces presses and releases, then delivers one single-cycle pulse per accepted key with a 2-bit key code.
- Runs on the 48 MHz HFOSC clock.

Parameters:
- SCAN_DIV, 48000, clock cycles each column is driven (1 ms at 48 MHz); minimum 4.
- DEBOUNCE_SCANS, 10, consecutive identical full-scan frames required to accept a press or release; minimum 1.
- REPEAT_DELAY, 500, frames before the first auto-repeat (used only with KB_REPEAT_EN).
- REPEAT_RATE, 100, frames between later auto-repeats (used only with KB_REPEAT_EN).

Ports:
- clk  input  1  system clock, 48 MHz.
- rst  input  1  reset; asynchronous assert, active-low.
- kbrow  input  2  row lines, pulled up; kbrow[r]=0 means the key at (row r, active column) is pressed.
- kbcol  output  2  column drive, active-low one-hot.
- key_code  output  2  accepted key index = row*2 + col.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  output  1  high from acceptance until the debounced release.

Behaviour:
- Reset, all asynchronous: kbcol=2'b10 (column 0 driven), key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters 0.
- kbrow passes through a 2-flop synchronizer, reset to 2'b11.
- Column scan:
  - A dwell counter runs 0..SCAN_DIV-1; col_idx toggles at wrap.
  - Synchronized rows are sampled on the last dwell cycle of each column.
  - After column 1 is sampled, a 4-bit frame snapshot is formed (bit k = key k pressed) and frame_tick pulses for one cycle.
  - The scan runs continuously and is never stalled.
- FSM, evaluated only on frame_tick:
  - IDLE: snapshot with exactly one bit set -> latch cand, deb_cnt=1, go DEBOUNCE. Zero bits or more than one bit -> stay in IDLE.
  - DEBOUNCE: snapshot == onehot(cand) -> deb_cnt++. Otherwise -> IDLE, no output.
  - DEBOUNCE accept: when deb_cnt reaches DEBOUNCE_SCANS, go PRESSED. In the next cycle: key_valid=1 for one cycle, key_code=cand, key_held=1.
  - If DEBOUNCE_SCANS=1, accept happens on the first matching frame.
  - PRESSED: only bit cand is examined; other keys are ignored. If cand is clear -> RELEASE with deb_cnt=1.
  - RELEASE: cand clear -> deb_cnt++. When deb_cnt reaches DEBOUNCE_SCANS -> IDLE and key_held=0. If cand is set again -> PRESSED with no new key_valid (treated as bounce).
- key_code holds its last accepted value until the next accept.
- Latency from a press that is stable before a frame starts to key_valid: DEBOUNCE_SCANS frames plus 1 cycle after that frame's frame_tick.
- Counters saturate and do not wrap.
- Reset mid-operation aborts any pending accept. No key_valid is generated for a key already held when reset releases until it passes full debounce from IDLE; it then generates exactly one key_valid.

Optional Feature:
- Macro: KB_REPEAT_EN.
- Defined: while in PRESSED, a frame counter starts at accept.
  - An extra key_valid (same key_code) fires REPEAT_DELAY frames after accept, then every REPEAT_RATE frames.
  - The counter clears on leaving PRESSED. The RELEASE->PRESSED bounce path continues the count without clearing it.
- Undefined: no repeat logic is built. REPEAT_* parameters are accepted but ignored. Exactly one key_valid per press.

Decomposition:
- Package kb_pkg holds:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE};
  - typedef key_code_t (2 bits);
  - constants NUM_ROWS=2 and NUM_COLS=2;
  - a function for the one-hot test.
- Sub-module kb_col_scan holds the dwell counter, col_idx, kbcol drive, sample strobe and snapshot assembly, and outputs snapshot and frame_tick.
- kb_scanner holds the synchronizer, FSM and optional repeat counter.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 8 cycles):
- Reset: hold rst=0 with random kbrow -> kbcol=2'b10 and all outputs 0. After release, kbcol toggles 10/01 every 4 cycles.
- Clean press of key 3 (kbrow[1]=0 while kbcol=01) for 6 frames -> exactly one key_valid, key_code=3, key_held=1. After release, key_held drops on the 3rd clean frame_tick.
- Bounce: key 2 pressed 2 frames, released 1, pressed 5 -> a single key_valid with key_code=2, 3 frames after the re-press begins. No pulse earlier.
- Simultaneous keys 0 and 1 -> no key_valid. Release key 1 while holding 0 -> key_valid with key_code=0 after 3 frames. In PRESSED, adding key 3 has no effect.
- Reset asserted during DEBOUNCE and again during PRESSED -> outputs return to reset values immediately, with no stray key_valid. Key still held -> re-accepted once after 3 frames.
- KB_REPEAT_EN with REPEAT_DELAY=4, REPEAT_RATE=2, key 1 held 12 frames -> key_valid at accept, then at accept+4 and accept+6 frames, continuing every 2 frames. None after release.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared types, constants and helpers for the 2x2 keypad scanner.
package kb_pkg;

    localparam int NUM_ROWS = 2;
    localparam int NUM_COLS = 2;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kb_state_e;

    // True when exactly one key of the frame snapshot is down.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the (single) set bit of a snapshot.
    function automatic key_code_t onehot_index(input logic [NUM_KEYS-1:0] v);
        key_code_t idx;
        idx = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (v[k]) idx = key_code_t'(k);
        end
        return idx;
    endfunction

    // Snapshot pattern in which only the given key is down.
    function automatic logic [NUM_KEYS-1:0] key_mask(input key_code_t c);
        return {{(NUM_KEYS-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/kb_col_scan.sv
// Column scanner: drives one active-low column at a time for SCAN_DIV cycles,
// samples the synchronized rows on the last dwell cycle of each column and
// publishes a full 4-key snapshot with a one-cycle frame_tick after column 1.
module kb_col_scan
    import kb_pkg::*;
#(
    parameter int SCAN_DIV = 48000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] rows_i,
    output logic [NUM_COLS-1:0] kbcol,
    output logic [NUM_KEYS-1:0] snapshot_o,
    output logic                frame_tick_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0]       dwell_q, dwell_d;
    logic                col_q, col_d;
    logic [NUM_ROWS-1:0] col0_q, col0_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic                tick_q, tick_d;
    logic                last_dwell;

    assign last_dwell = (dwell_q == DWELL_LAST);

    // Dwell counting, column toggle, per-column sampling and snapshot assembly.
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        col_d   = col_q;
        col0_d  = col0_q;
        snap_d  = snap_q;
        tick_d  = 1'b0;
        if (last_dwell) begin
            dwell_d = '0;
            col_d   = ~col_q;
            if (!col_q) begin
                col0_d = ~rows_i;
            end else begin
                // bit k = key (row*2 + col) pressed
                snap_d = {~rows_i[1], col0_q[1], ~rows_i[0], col0_q[0]};
                tick_d = 1'b1;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_q <= '0;
            col_q   <= 1'b0;
            col0_q  <= '0;
            snap_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            col_q   <= col_d;
            col0_q  <= col0_d;
            snap_q  <= snap_d;
            tick_q  <= tick_d;
        end
    end

    // Column 0 -> 2'b10, column 1 -> 2'b01, straight from the flop.
    assign kbcol        = {~col_q, col_q};
    assign snapshot_o   = snap_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/kb_scanner.sv
// 2x2 keypad front end: row synchronizer, frame-based press/release debounce
// FSM and key strobe generation. Defining KB_REPEAT_EN adds auto-repeat of
// the held key (REPEAT_DELAY frames after accept, then every REPEAT_RATE).
module kb_scanner
    import kb_pkg::*;
#(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [1:0] kbrow,
    output logic [1:0] kbcol,
    output logic [1:0] key_code,
    output logic      key_valid,
    output logic      key_held
);

    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] snapshot;
    logic                frame_tick;

    kb_state_e        state_q, state_d;
    key_code_t        cand_q, cand_d;
    key_code_t        code_q, code_d;
    logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             accept, to_idle;

`ifdef KB_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep_q, rep_d, rep_inc, rep_target;
    logic             rep_first_q, rep_first_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
`endif

    // Two-flop synchronizer on the asynchronous row lines (idle = pulled up).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= kbrow;
            sync2_q <= sync1_q;
        end
    end

    kb_col_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_col_scan (
        .clk         (clk),
        .rst         (rst),
        .rows_i      (sync2_q),
        .kbcol       (kbcol),
        .snapshot_o  (snapshot),
        .frame_tick_o(frame_tick)
    );

    assign deb_inc = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
`ifdef KB_REPEAT_EN
    assign rep_inc    = (rep_q == {REP_W{1'b1}}) ? rep_q : rep_q + 1'b1;
    assign rep_target = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
`endif

    // Debounce FSM: next state and strobes, evaluated once per frame_tick.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        deb_d   = deb_q;
        valid_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;
        to_idle = 1'b0;
`ifdef KB_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (is_onehot(snapshot)) begin
                        cand_d  = onehot_index(snapshot);
                        deb_d   = DEB_ONE;
                        state_d = DEBOUNCE;
                        accept  = (DEB_ONE == DEB_MAX);
                    end
                end
                DEBOUNCE: begin
                    if (snapshot == key_mask(cand_q)) begin
                        deb_d  = deb_inc;
                        accept = (deb_inc == DEB_MAX);
                    end else begin
                        state_d = IDLE;
                        deb_d   = '0;
                    end
                end
                PRESSED: begin
                    // Only the accepted key matters here; others are ignored.
                    if (!snapshot[cand_q]) begin
                        state_d = RELEASE;
                        deb_d   = DEB_ONE;
                        to_idle = (DEB_ONE == DEB_MAX);
                    end else begin
`ifdef KB_REPEAT_EN
                        if (rep_inc == rep_target) begin
                            valid_d     = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_d = rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (!snapshot[cand_q]) begin
                        deb_d   = deb_inc;
                        to_idle = (deb_inc == DEB_MAX);
                    end else begin
                        // Bounce back to held; repeat count resumes where it was.
                        state_d = PRESSED;
                        deb_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            state_d = PRESSED;
            deb_d   = '0;
            valid_d = 1'b1;
            code_d  = cand_d;
            held_d  = 1'b1;
`ifdef KB_REPEAT_EN
            rep_d       = '0;
            rep_first_d = 1'b1;
`endif
        end
        if (to_idle) begin
            state_d = IDLE;
            deb_d   = '0;
            held_d  = 1'b0;
`ifdef KB_REPEAT_EN
            rep_d       = '0;
            rep_first_d = 1'b1;
`endif
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= '0;
            deb_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            deb_q   <= deb_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

`ifdef KB_REPEAT_EN
    // Auto-repeat frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
